// File: rtl/snake_move_scheduler_if.sv
// Signal bundle between the snake move scheduler and its neighbours:
// key debouncers, game control FSM and the snake body/collision datapath.
interface snake_move_scheduler_if;
    // All inputs are single-cycle pulses or levels sampled on clk; outputs are registered.
    logic       key1_press;
    logic       key2_press;
    logic       key3_press;
    logic       key4_press;
    logic [1:0] game_status;
    logic       restart;
    logic       apple_eaten;
    logic       move_tick;
    logic [1:0] dir;
    logic [3:0] speed_level;
    logic       turn_q_full;

    modport master (
        output key1_press, key2_press, key3_press, key4_press,
        output game_status, restart, apple_eaten,
        input  move_tick, dir, speed_level, turn_q_full
    );

    modport slave (
        input  key1_press, key2_press, key3_press, key4_press,
        input  game_status, restart, apple_eaten,
        output move_tick, dir, speed_level, turn_q_full
    );
endinterface

// File: rtl/snake_move_scheduler.sv
// Move pacing and steering for the snake: periodic move_tick, 2-deep turn queue
// feeding the heading, and an apple-driven speed level that shortens the period.
module snake_move_scheduler #(
    parameter int unsigned BASE_PERIOD = 12_500_000,
    parameter int unsigned STEP_PERIOD = 1_000_000,
    parameter int unsigned MAX_LEVEL   = 10,
    parameter int unsigned LEVEL_EVERY = 4
) (
    input logic                   clk,
    input logic                   rst,
    snake_move_scheduler_if.slave bus
);
    localparam logic [1:0]  ST_START = 2'b01;
    localparam logic [1:0]  ST_PLAY  = 2'b10;
    localparam logic [31:0] BASE_P   = BASE_PERIOD;
    localparam logic [31:0] STEP_P   = STEP_PERIOD;
    localparam logic [31:0] LEVEL_M1 = LEVEL_EVERY - 1;
    localparam logic [3:0]  MAX_L    = 4'(MAX_LEVEL);

    logic        r_tick;
    logic [1:0]  r_dir;
    logic [3:0]  r_level;
    logic [1:0]  r_q0;
    logic [1:0]  r_q1;
    logic [1:0]  r_qcnt;
    logic        r_full;
    logic [31:0] r_cnt;
    logic [31:0] r_apples;

    logic        w_play;
    logic        w_keys_ok;
    logic [31:0] w_period_m1;
    logic        w_pop;
    logic        w_req_valid;
    logic [1:0]  w_req_dir;
    logic [1:0]  w_ref;
    logic        w_turn_ok;
    logic        w_push;
    logic [1:0]  w_dir_n;
    logic [1:0]  w_q0_n;
    logic [1:0]  w_q1_n;
    logic [1:0]  w_qcnt_n;
    logic [31:0] w_cnt_n;
    logic [3:0]  w_level_n;
    logic [31:0] w_apples_n;

    assign w_play      = (bus.game_status == ST_PLAY);
    assign w_keys_ok   = (bus.game_status == ST_START) || w_play;
    assign w_period_m1 = BASE_P - (32'(r_level) * STEP_P) - 32'd1;
    // >= rather than == so a period that shrinks below the running count still fires.
    assign w_pop       = w_play && (r_cnt >= w_period_m1);

    always_comb begin
        w_req_valid = w_keys_ok;
        w_req_dir   = 2'b00;
        if (bus.key1_press) begin
            w_req_dir = 2'b00;
        end else if (bus.key2_press) begin
            w_req_dir = 2'b01;
        end else if (bus.key3_press) begin
            w_req_dir = 2'b10;
        end else if (bus.key4_press) begin
            w_req_dir = 2'b11;
        end else begin
            w_req_valid = 1'b0;
        end
    end

    // A turn is legal only onto the other axis: same or opposite heading share bit 1.
    assign w_ref     = (r_qcnt == 2'd0) ? r_dir : ((r_qcnt == 2'd1) ? r_q0 : r_q1);
    assign w_turn_ok = w_req_valid && (w_req_dir[1] != w_ref[1]);
    assign w_push    = w_turn_ok && ((r_qcnt != 2'd2) || w_pop);

    always_comb begin
        w_dir_n  = r_dir;
        w_q0_n   = r_q0;
        w_q1_n   = r_q1;
        w_qcnt_n = r_qcnt;
        if (w_pop && (r_qcnt != 2'd0)) begin
            w_dir_n  = r_q0;
            w_q0_n   = r_q1;
            w_qcnt_n = r_qcnt - 2'd1;
        end
        if (w_push) begin
            if (w_qcnt_n == 2'd0) begin
                w_q0_n = w_req_dir;
            end else begin
                w_q1_n = w_req_dir;
            end
            w_qcnt_n = w_qcnt_n + 2'd1;
        end
    end

    always_comb begin
        w_cnt_n = r_cnt;
        if (w_pop) begin
            w_cnt_n = 32'd0;
        end else if (w_play) begin
            w_cnt_n = r_cnt + 32'd1;
        end
    end

    always_comb begin
        w_level_n  = r_level;
        w_apples_n = r_apples;
        if (w_play && bus.apple_eaten) begin
            if (r_apples >= LEVEL_M1) begin
                w_apples_n = 32'd0;
                if (r_level < MAX_L) begin
                    w_level_n = r_level + 4'd1;
                end
            end else begin
                w_apples_n = r_apples + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick   <= 1'b0;
            r_dir    <= 2'b11;
            r_level  <= 4'd0;
            r_q0     <= 2'b00;
            r_q1     <= 2'b00;
            r_qcnt   <= 2'd0;
            r_full   <= 1'b0;
            r_cnt    <= 32'd0;
            r_apples <= 32'd0;
        end else if (!bus.restart) begin
            r_tick   <= 1'b0;
            r_dir    <= 2'b11;
            r_level  <= 4'd0;
            r_q0     <= 2'b00;
            r_q1     <= 2'b00;
            r_qcnt   <= 2'd0;
            r_full   <= 1'b0;
            r_cnt    <= 32'd0;
            r_apples <= 32'd0;
        end else begin
            r_tick   <= w_pop;
            r_dir    <= w_dir_n;
            r_level  <= w_level_n;
            r_q0     <= w_q0_n;
            r_q1     <= w_q1_n;
            r_qcnt   <= w_qcnt_n;
            r_full   <= (w_qcnt_n == 2'd2);
            r_cnt    <= w_cnt_n;
            r_apples <= w_apples_n;
        end
    end

    assign bus.move_tick   = r_tick;
    assign bus.dir         = r_dir;
    assign bus.speed_level = r_level;
    assign bus.turn_q_full = r_full;
endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench for snake_move_scheduler with a queue-based reference model
// checked every cycle, plus literal expectations at scenario milestones.
module tb_snake_move_scheduler;
  localparam int BASE  = 10;
  localparam int STEP  = 2;
  localparam int MAXL  = 3;
  localparam int EVERY = 2;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
  localparam logic [1:0] S_RESTART = 2'd0, S_START = 2'd1, S_PLAY = 2'd2, S_DIE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   cmp_en = 1'b0;

  snake_move_scheduler_if bus();

  snake_move_scheduler #(
    .BASE_PERIOD(BASE),
    .STEP_PERIOD(STEP),
    .MAX_LEVEL(MAXL),
    .LEVEL_EVERY(EVERY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: heading, pending turns as a queue, level, apples, PLAY cycles since last tick
  logic [1:0] m_q[$];
  logic [1:0] m_dir;
  int         m_level;
  int         m_apples;
  int         m_elapsed;
  bit         m_tick;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin : model
    bit         pop;
    bit         take;
    logic [1:0] req;
    logic [1:0] refd;
    if (!rst || !bus.restart) begin
      m_q.delete();
      m_dir     = RIGHT;
      m_level   = 0;
      m_apples  = 0;
      m_elapsed = 0;
      m_tick    = 1'b0;
    end else begin
      pop    = 1'b0;
      take   = 1'b0;
      req    = UP;
      m_tick = 1'b0;
      if (bus.game_status == S_PLAY) begin
        m_elapsed++;
        if (m_elapsed >= BASE - m_level * STEP) begin
          pop       = 1'b1;
          m_tick    = 1'b1;
          m_elapsed = 0;
        end
      end
      if (bus.game_status == S_START || bus.game_status == S_PLAY) begin
        take = 1'b1;
        if (bus.key1_press) req = UP;
        else if (bus.key2_press) req = DOWN;
        else if (bus.key3_press) req = LEFT;
        else if (bus.key4_press) req = RIGHT;
        else take = 1'b0;
      end
      refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
      if (req == refd || req == opposite(refd)) take = 1'b0;
      if (pop && m_q.size() > 0) m_dir = m_q.pop_front();
      if (take && m_q.size() < 2) m_q.push_back(req);
      if (bus.game_status == S_PLAY && bus.apple_eaten) begin
        m_apples++;
        if (m_apples == EVERY) begin
          m_apples = 0;
          if (m_level < MAXL) m_level++;
        end
      end
    end
  end

  // scoreboard: compare every cycle away from the active edge
  int tick_cnt = 0;
  always @(negedge clk) begin
    if (bus.move_tick === 1'b1) tick_cnt++;
    if (cmp_en) begin
      check("model move_tick", bus.move_tick, m_tick);
      check("model dir", bus.dir, m_dir);
      check("model speed_level", bus.speed_level, m_level);
      check("model turn_q_full", bus.turn_q_full, (m_q.size() == 2));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_keys(input logic [3:0] m);
    {bus.key4_press, bus.key3_press, bus.key2_press, bus.key1_press} = m;
    step();
    {bus.key4_press, bus.key3_press, bus.key2_press, bus.key1_press} = 4'b0000;
  endtask

  task automatic pulse_apples(input int n);
    for (int i = 0; i < n; i++) begin
      bus.apple_eaten = 1'b1;
      step();
      bus.apple_eaten = 1'b0;
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.move_tick !== 1'b1 && n < 64);
    if (bus.move_tick !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: got no move_tick in %0d cycles, expected one", n);
    end
  endtask

  initial begin
    int n;
    int t0;
    bus.key1_press  = 1'b0;
    bus.key2_press  = 1'b0;
    bus.key3_press  = 1'b0;
    bus.key4_press  = 1'b0;
    bus.apple_eaten = 1'b0;
    bus.restart     = 1'b1;
    bus.game_status = S_RESTART;
    rst = 1'b0;
    repeat (3) step();
    check("reset move_tick", bus.move_tick, 0);
    check("reset dir", bus.dir, RIGHT);
    check("reset speed_level", bus.speed_level, 0);
    check("reset turn_q_full", bus.turn_q_full, 0);
    rst = 1'b1;
    step();
    cmp_en = 1'b1;

    // 1: free-running ticks every 10 cycles, heading unchanged
    bus.game_status = S_PLAY;
    wait_tick(n);
    check("t1 first tick latency", n, 10);
    check("t1 dir after tick1", bus.dir, RIGHT);
    wait_tick(n);
    check("t1 tick spacing 2", n, 10);
    wait_tick(n);
    check("t1 tick spacing 3", n, 10);
    check("t1 dir after tick3", bus.dir, RIGHT);

    // 2: opposite dropped, legal turn applied, priority key2 over key4
    pulse_keys(4'b0100);
    check("t2 left dropped full", bus.turn_q_full, 0);
    pulse_keys(4'b0001);
    wait_tick(n);
    check("t2 up applied", bus.dir, UP);
    pulse_keys(4'b1010);
    wait_tick(n);
    check("t2 key2 priority over key4", bus.dir, UP);
    pulse_keys(4'b1000);
    wait_tick(n);
    check("t2 right applied", bus.dir, RIGHT);

    // 3: queue fills at two, third request dropped, drained one per tick
    pulse_keys(4'b0001);
    check("t3 one queued", bus.turn_q_full, 0);
    pulse_keys(4'b0100);
    check("t3 two queued", bus.turn_q_full, 1);
    pulse_keys(4'b0010);
    check("t3 still full", bus.turn_q_full, 1);
    wait_tick(n);
    check("t3 first pop dir", bus.dir, UP);
    check("t3 first pop full", bus.turn_q_full, 0);
    wait_tick(n);
    check("t3 second pop dir", bus.dir, LEFT);
    wait_tick(n);
    check("t3 no third pop", bus.dir, LEFT);
    pulse_keys(4'b1001);
    wait_tick(n);
    check("t3 key1 priority over key4", bus.dir, UP);

    // 4: speed levels shorten the period and saturate
    pulse_apples(2);
    check("t4 level after 2 apples", bus.speed_level, 1);
    wait_tick(n);
    wait_tick(n);
    check("t4 spacing level1", n, 8);
    pulse_apples(4);
    check("t4 level after 6 apples", bus.speed_level, 3);
    wait_tick(n);
    wait_tick(n);
    check("t4 spacing level3", n, 4);
    pulse_apples(2);
    check("t4 level saturated", bus.speed_level, 3);
    wait_tick(n);
    wait_tick(n);
    check("t4 spacing saturated", n, 4);

    // 5: DIE freezes everything; restart clears
    step();
    step();
    bus.game_status = S_DIE;
    t0 = tick_cnt;
    pulse_keys(4'b0100);
    pulse_apples(2);
    repeat (12) step();
    check("t5 no ticks in DIE", tick_cnt - t0, 0);
    check("t5 dir frozen", bus.dir, UP);
    check("t5 level frozen", bus.speed_level, 3);
    check("t5 key ignored", bus.turn_q_full, 0);
    bus.restart = 1'b0;
    repeat (3) step();
    bus.restart = 1'b1;
    check("t5 restart dir", bus.dir, RIGHT);
    check("t5 restart level", bus.speed_level, 0);
    check("t5 restart move_tick", bus.move_tick, 0);
    bus.game_status = S_PLAY;
    wait_tick(n);
    check("t5 counter cleared latency", n, 10);

    // 6: async reset mid-period with full queue, then keys queued in START
    pulse_apples(4);
    check("t6 level 2", bus.speed_level, 2);
    wait_tick(n);
    pulse_keys(4'b0001);
    pulse_keys(4'b0100);
    check("t6 queue full", bus.turn_q_full, 1);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("t6 async move_tick", bus.move_tick, 0);
    check("t6 async dir", bus.dir, RIGHT);
    check("t6 async level", bus.speed_level, 0);
    check("t6 async full", bus.turn_q_full, 0);
    bus.game_status = S_START;
    step();
    rst = 1'b1;
    step();
    pulse_keys(4'b0001);
    t0 = tick_cnt;
    repeat (6) step();
    check("t6 no ticks in START", tick_cnt - t0, 0);
    check("t6 dir held in START", bus.dir, RIGHT);
    bus.game_status = S_PLAY;
    wait_tick(n);
    check("t6 first PLAY tick latency", n, 10);
    check("t6 START key applied", bus.dir, UP);
    step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
